// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and timing defaults for the reset sequencer
package rst_seq_pkg;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_REL  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int HOLD_CYC_DEF = 128;
    localparam int STEP_CYC_DEF = 16;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous active-low clear
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staggered per-domain reset release with lock supervision and soft reset
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM  = 4,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int STEP_CYC = STEP_CYC_DEF
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic               LOCKED,
    input  logic               SRST_REQ,
    output logic               SRST_ACK,
    output logic [NUM_DOM-1:0] RST_X_O,
    output logic               READY
);

    localparam int HOLD_W = $clog2(HOLD_CYC);
    localparam int STEP_W = $clog2(STEP_CYC + 1);
    localparam int IDX_W  = $clog2(NUM_DOM + 1);

    logic               rst_s;
    logic               lock_s;
    logic               ok;
    logic [1:0]         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] rst_q, rst_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;

    // The raw reset clears immediately but its release is resynchronized.
    sync2 #(.RST_VAL(1'b0)) u_sync_rst (
        .clk   (CLK),
        .rst_n (RST_X),
        .d_i   (1'b1),
        .q_o   (rst_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_lock (
        .clk   (CLK),
        .rst_n (RST_X),
        .d_i   (LOCKED),
        .q_o   (lock_s)
    );

    assign ok = rst_s & lock_s;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        step_d  = step_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        if (!ok) begin
            // Lock loss wins over a pending soft-reset request: no acknowledge.
            state_d = ST_HOLD;
            hold_d  = '0;
            step_d  = '0;
            idx_d   = '0;
            rst_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                        rst_d  = NUM_DOM'(1);
                        idx_d  = IDX_W'(1);
                        hold_d = '0;
                        step_d = '0;
                        if (NUM_DOM == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_REL;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_REL: begin
                    if (step_q == STEP_W'(STEP_CYC - 1)) begin
                        step_d = '0;
                        for (int i = 0; i < NUM_DOM; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_d[i] = 1'b1;
                            end
                        end
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(NUM_DOM - 1)) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
                ST_RUN: begin
                    if (SRST_REQ) begin
                        ack_d   = 1'b1;
                        state_d = ST_HOLD;
                        hold_d  = '0;
                        step_d  = '0;
                        idx_d   = '0;
                        rst_d   = '0;
                        ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    step_d  = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    assign RST_X_O  = rst_q;
    assign READY    = ready_q;
    assign SRST_ACK = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - bench for rst_sequencer: default build plus a single-domain minimal-timing build
module tb_rst_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic       rst_x_a = 1'b1, locked_a = 1'b0, req_a = 1'b0;
    logic       ack_a, ready_a;
    logic [3:0] rsto_a;
    logic       rst_x_b = 1'b1, locked_b = 1'b0, req_b = 1'b0;
    logic       ack_b, ready_b;
    logic [0:0] rsto_b;

    rst_sequencer dut_a (
        .CLK      (clk),
        .RST_X    (rst_x_a),
        .LOCKED   (locked_a),
        .SRST_REQ (req_a),
        .SRST_ACK (ack_a),
        .RST_X_O  (rsto_a),
        .READY    (ready_a)
    );

    rst_sequencer #(.NUM_DOM(1), .HOLD_CYC(2), .STEP_CYC(1)) dut_b (
        .CLK      (clk),
        .RST_X    (rst_x_b),
        .LOCKED   (locked_b),
        .SRST_REQ (req_b),
        .SRST_ACK (ack_b),
        .RST_X_O  (rsto_b),
        .READY    (ready_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Wait until the falling edge that follows rising edge number n.
    task automatic at(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Released domain count, from edges elapsed since the sequence origin.
    function automatic int m_k(input int t, input int num, input int h, input int s);
        int k;
        if (t < h) return 0;
        k = (t - h) / s + 1;
        return (k > num) ? num : k;
    endfunction

    function automatic logic [31:0] m_mask(input int k);
        return (32'd1 << k) - 32'd1;
    endfunction

    int   ma_rel, ma_t, mb_rel, mb_t;
    logic ma_lock, ma_ok, ma_ack, mb_lock, mb_ok, mb_ack;

    always @(posedge clk or negedge rst_x_a) begin
        if (!rst_x_a) begin
            ma_rel <= 0; ma_lock <= 1'b0; ma_ok <= 1'b0; ma_t <= 0; ma_ack <= 1'b0;
        end else begin
            ma_rel  <= (ma_rel >= 2) ? 2 : ma_rel + 1;
            ma_lock <= locked_a;
            ma_ok   <= (ma_rel >= 1) && ma_lock;
            if (!ma_ok) begin
                ma_t <= 0; ma_ack <= 1'b0;
            end else if (m_k(ma_t, 4, 128, 16) == 4 && req_a) begin
                ma_t <= 0; ma_ack <= 1'b1;
            end else begin
                ma_t <= (ma_t >= 192) ? ma_t : ma_t + 1; ma_ack <= 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_x_b) begin
        if (!rst_x_b) begin
            mb_rel <= 0; mb_lock <= 1'b0; mb_ok <= 1'b0; mb_t <= 0; mb_ack <= 1'b0;
        end else begin
            mb_rel  <= (mb_rel >= 2) ? 2 : mb_rel + 1;
            mb_lock <= locked_b;
            mb_ok   <= (mb_rel >= 1) && mb_lock;
            if (!mb_ok) begin
                mb_t <= 0; mb_ack <= 1'b0;
            end else if (m_k(mb_t, 1, 2, 1) == 1 && req_b) begin
                mb_t <= 0; mb_ack <= 1'b1;
            end else begin
                mb_t <= (mb_t >= 3) ? mb_t : mb_t + 1; mb_ack <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_a_rst",   rsto_a,  m_mask(m_k(ma_t, 4, 128, 16)));
        chk("model_a_ready", ready_a, m_k(ma_t, 4, 128, 16) == 4);
        chk("model_a_ack",   ack_a,   ma_ack);
        chk("model_b_rst",   rsto_b,  m_mask(m_k(mb_t, 1, 2, 1)));
        chk("model_b_ready", ready_b, m_k(mb_t, 1, 2, 1) == 1);
        chk("model_b_ack",   ack_b,   mb_ack);
    end

    initial begin
        #1 rst_x_b = 1'b0;
        #1 chk("b_reset_rst", rsto_b, 0);
        #1 rst_x_b = 1'b1; locked_b = 1'b1;
        at(3);  chk("b_t1_rst", rsto_b, 0); chk("b_t1_ready", ready_b, 0);
        at(4);  chk("b_t2_rst", rsto_b, 1); chk("b_t2_ready", ready_b, 1);
        at(10); locked_b = 1'b0;
        at(13); chk("b_lockloss_rst", rsto_b, 0); req_b = 1'b1; locked_b = 1'b1;
        at(16); chk("b_hold_noack", ack_b, 0); chk("b_hold_ready", ready_b, 0);
        at(17); chk("b_run_ready", ready_b, 1); chk("b_run_noack", ack_b, 0);
        at(18); chk("b_ack", ack_b, 1); chk("b_ack_rst", rsto_b, 0); req_b = 1'b0;
        at(19); chk("b_ack_once", ack_b, 0);
        at(20); chk("b_rerun_ready", ready_b, 1);
    end

    initial begin
        #1 rst_x_a = 1'b0;
        #1 chk("a_reset_rst", rsto_a, 0); chk("a_reset_ready", ready_a, 0); chk("a_reset_ack", ack_a, 0);
        #1 rst_x_a = 1'b1; locked_a = 1'b1;
        at(129); chk("a_t127", rsto_a, 4'b0000);
        at(130); chk("a_t128", rsto_a, 4'b0001);
        at(146); chk("a_t144", rsto_a, 4'b0011);
        at(162); chk("a_t160", rsto_a, 4'b0111);
        at(177); chk("a_t175_ready", ready_a, 0);
        at(178); chk("a_t176", rsto_a, 4'b1111); chk("a_t176_ready", ready_a, 1);
        at(190); req_a = 1'b1;
        at(191); chk("a_srst_ack", ack_a, 1); chk("a_srst_rst", rsto_a, 0); chk("a_srst_ready", ready_a, 0);
        req_a = 1'b0;
        at(192); chk("a_srst_ack_once", ack_a, 0);
        at(318); chk("a_s127", rsto_a, 4'b0000);
        at(319); chk("a_s128", rsto_a, 4'b0001);
        at(341); chk("a_s150", rsto_a, 4'b0011); locked_a = 1'b0;
        at(343); chk("a_lock_sync", rsto_a, 4'b0011);
        at(344); chk("a_lock_drop", rsto_a, 4'b0000);
        at(346); locked_a = 1'b1;
        at(475); chk("a_l127", rsto_a, 4'b0000);
        at(476); chk("a_l128", rsto_a, 4'b0001);
        at(524); chk("a_l176_ready", ready_a, 1);
        at(530); locked_a = 1'b0;
        at(532); chk("a_pre_both_ready", ready_a, 1); req_a = 1'b1;
        at(533); chk("a_both_noack", ack_a, 0); chk("a_both_rst", rsto_a, 0); chk("a_both_ready", ready_a, 0);
        req_a = 1'b0;
        at(535); locked_a = 1'b1;
        at(707); chk("a_u170", rsto_a, 4'b0111);
        #2 rst_x_a = 1'b0;
        #1 chk("a_async_rst", rsto_a, 0); chk("a_async_ready", ready_a, 0);
        at(710); #3 rst_x_a = 1'b1;
        at(839); chk("a_r127", rsto_a, 4'b0000);
        at(840); chk("a_r128", rsto_a, 4'b0001);
        at(888); chk("a_r176", rsto_a, 4'b1111); chk("a_r176_ready", ready_a, 1);
        at(900);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
